// File: rtl/sfu_stream_if.sv
// Signal bundle for sfu_stream: input beat, output beat, configuration and statistics.
// The master side is the upstream/downstream environment; the slave side is the unit itself.
interface sfu_stream_if #(
  parameter int LANES  = 16,
  parameter int IN_W   = 8,
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16
) ();

  logic                     in_valid;
  logic                     in_ready;
  logic [LANES*IN_W-1:0]    in_q;
  logic [LANES-1:0]         in_obm;
  logic [LANES*DATA_W-1:0]  in_odelta;
  logic [LANES-1:0]         in_sign;
  logic [LANES*DATA_W-1:0]  in_xprev;
  logic                     in_last;
  logic                     cfg_relu_en;

  logic                     out_valid;
  logic                     out_ready;
  logic [LANES*DATA_W-1:0]  out_x;
  logic [LANES*DATA_W-1:0]  out_relu;
  logic [LANES-1:0]         out_ovf;
  logic [LANES-1:0]         out_sat;
  logic                     out_last;
  logic                     tile_done;

  logic                     stat_clr;
  logic [CNT_W-1:0]         stat_outliers;
  logic [CNT_W-1:0]         stat_err;
  logic [CNT_W-1:0]         stat_sat;

  modport master (
    output in_valid, in_q, in_obm, in_odelta, in_sign, in_xprev, in_last,
           cfg_relu_en, out_ready, stat_clr,
    input  in_ready, out_valid, out_x, out_relu, out_ovf, out_sat, out_last,
           tile_done, stat_outliers, stat_err, stat_sat
  );

  modport slave (
    input  in_valid, in_q, in_obm, in_odelta, in_sign, in_xprev, in_last,
           cfg_relu_en, out_ready, stat_clr,
    output in_ready, out_valid, out_x, out_relu, out_ovf, out_sat, out_last,
           tile_done, stat_outliers, stat_err, stat_sat
  );

endinterface

// File: rtl/sfu_stream.sv
// Two-stage special-function unit: inlier decompress / outlier substitute, sign-bit ReLU,
// saturating read-add-write of the activation, plus saturating per-tile statistics.
module sfu_stream #(
  parameter int LANES      = 16,
  parameter int IN_W       = 8,
  parameter int DATA_W     = 16,
  parameter int FRAC_SHIFT = 4,
  parameter int CNT_W      = 16
) (
  input logic         clk,
  input logic         rst_n,
  sfu_stream_if.slave stream
);

  localparam int XW   = LANES * DATA_W;
  localparam int PC_W = $clog2(LANES + 1);
  localparam logic [IN_W-1:0]   SENTINEL = {1'b1, {(IN_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] POS_MAX  = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] NEG_MIN  = {1'b1, {(DATA_W-1){1'b0}}};

  logic             en, inFire, s1Adv;

  logic             s1Valid_q, s1Last_q;
  logic [XW-1:0]    s1Delta_q, s1Xprev_q;
  logic [LANES-1:0] s1Ovf_q, s1Err_q, s1Sign_q;

  logic             outValid_q, outLast_q, tileDone_q;
  logic [XW-1:0]    outX_q, outRelu_q;
  logic [LANES-1:0] outOvf_q, outSat_q;

  logic [CNT_W-1:0] statOutliers_q, statErr_q, statSat_q;

  logic [XW-1:0]    decDelta_d, relu_d, sum_d;
  logic [LANES-1:0] decOvf_d, decErr_d, sat_d;

  function automatic logic [PC_W-1:0] popcount(input logic [LANES-1:0] v);
    logic [PC_W-1:0] c;
    c = '0;
    for (int i = 0; i < LANES; i++) c = c + PC_W'(v[i]);
    return c;
  endfunction

  function automatic logic [CNT_W-1:0] satAdd(input logic [CNT_W-1:0] a, input logic [PC_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + (CNT_W+1)'(b);
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  // The whole pipe moves together; only a stalled output beat blocks it.
  assign en     = ~outValid_q | stream.out_ready;
  assign inFire = stream.in_valid & en;
  assign s1Adv  = s1Valid_q & en;

  always_comb begin
    decDelta_d = '0;
    decOvf_d   = '0;
    decErr_d   = '0;
    for (int i = 0; i < LANES; i++) begin
      decOvf_d[i] = (stream.in_q[i*IN_W +: IN_W] == SENTINEL);
      decErr_d[i] = decOvf_d[i] & ~stream.in_obm[i];
      if (stream.in_obm[i])
        decDelta_d[i*DATA_W +: DATA_W] = stream.in_odelta[i*DATA_W +: DATA_W];
      else if (!decOvf_d[i])
        decDelta_d[i*DATA_W +: DATA_W] = DATA_W'($signed(stream.in_q[i*IN_W +: IN_W])) << FRAC_SHIFT;
    end
  end

  // One extra bit of headroom exposes overflow as a mismatch of the top two sum bits.
  always_comb begin
    logic [DATA_W-1:0] xp, r;
    logic [DATA_W:0]   wide;
    relu_d = '0;
    sum_d  = '0;
    sat_d  = '0;
    xp     = '0;
    r      = '0;
    wide   = '0;
    for (int i = 0; i < LANES; i++) begin
      xp   = s1Xprev_q[i*DATA_W +: DATA_W];
      r    = (~stream.cfg_relu_en | s1Sign_q[i]) ? s1Delta_q[i*DATA_W +: DATA_W] : '0;
      wide = {xp[DATA_W-1], xp} + {r[DATA_W-1], r};
      sat_d[i] = wide[DATA_W] ^ wide[DATA_W-1];
      relu_d[i*DATA_W +: DATA_W] = r;
      if (sat_d[i])
        sum_d[i*DATA_W +: DATA_W] = wide[DATA_W] ? NEG_MIN : POS_MAX;
      else
        sum_d[i*DATA_W +: DATA_W] = wide[DATA_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1Valid_q  <= 1'b0;
      s1Last_q   <= 1'b0;
      s1Delta_q  <= '0;
      s1Xprev_q  <= '0;
      s1Ovf_q    <= '0;
      s1Err_q    <= '0;
      s1Sign_q   <= '0;
      outValid_q <= 1'b0;
      outLast_q  <= 1'b0;
      outX_q     <= '0;
      outRelu_q  <= '0;
      outOvf_q   <= '0;
      outSat_q   <= '0;
    end else if (en) begin
      s1Valid_q  <= stream.in_valid;
      outValid_q <= s1Valid_q;
      if (stream.in_valid) begin
        s1Delta_q <= decDelta_d;
        s1Xprev_q <= stream.in_xprev;
        s1Ovf_q   <= decOvf_d;
        s1Err_q   <= decErr_d;
        s1Sign_q  <= stream.in_sign;
        s1Last_q  <= stream.in_last;
      end
      if (s1Valid_q) begin
        outX_q    <= sum_d;
        outRelu_q <= relu_d;
        outOvf_q  <= s1Ovf_q;
        outSat_q  <= sat_d;
        outLast_q <= s1Last_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tileDone_q <= 1'b0;
    else        tileDone_q <= outValid_q & stream.out_ready & outLast_q;
  end

  // A clear in the same cycle as an increment discards that increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      statOutliers_q <= '0;
      statErr_q      <= '0;
      statSat_q      <= '0;
    end else if (stream.stat_clr) begin
      statOutliers_q <= '0;
      statErr_q      <= '0;
      statSat_q      <= '0;
    end else begin
      if (inFire) statOutliers_q <= satAdd(statOutliers_q, popcount(stream.in_obm));
      if (s1Adv) begin
        statErr_q <= satAdd(statErr_q, popcount(s1Err_q));
        statSat_q <= satAdd(statSat_q, popcount(sat_d));
      end
    end
  end

  assign stream.in_ready      = en;
  assign stream.out_valid     = outValid_q;
  assign stream.out_x         = outX_q;
  assign stream.out_relu      = outRelu_q;
  assign stream.out_ovf       = outOvf_q;
  assign stream.out_sat       = outSat_q;
  assign stream.out_last      = outLast_q;
  assign stream.tile_done     = tileDone_q;
  assign stream.stat_outliers = statOutliers_q;
  assign stream.stat_err      = statErr_q;
  assign stream.stat_sat      = statSat_q;

endmodule

// File: tb/tb_sfu_stream.sv
// Scoreboard bench for sfu_stream at LANES=4: an integer reference model queues expected
// beats at acceptance and a negedge monitor pops and compares them at each output handshake.
module tb_sfu_stream;

  localparam int LANES      = 4;
  localparam int IN_W       = 8;
  localparam int DATA_W     = 16;
  localparam int FRAC_SHIFT = 4;
  localparam int CNT_W      = 16;
  localparam int XW         = LANES * DATA_W;

  typedef struct {
    int               q      [LANES];
    int               odelta [LANES];
    int               xprev  [LANES];
    logic [LANES-1:0] obm;
    logic [LANES-1:0] sign;
    logic             last;
  } beat_t;

  typedef struct packed {
    logic [XW-1:0]    x;
    logic [XW-1:0]    relu;
    logic [LANES-1:0] ovf;
    logic [LANES-1:0] sat;
    logic             last;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic randReady  = 1'b0;
  logic readyLevel = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   cycleCount = 0;
  int   acceptCycle = 0;
  int   mOutliers = 0;
  int   mErr = 0;
  int   mSat = 0;
  exp_t expQ[$];

  sfu_stream_if #(.LANES(LANES), .IN_W(IN_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  sfu_stream #(
    .LANES(LANES), .IN_W(IN_W), .DATA_W(DATA_W), .FRAC_SHIFT(FRAC_SHIFT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .stream(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycleCount <= cycleCount + 1;

  task automatic checkOutput(input string tag, input logic [XW-1:0] observed, input logic [XW-1:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic int satCnt(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  function automatic exp_t modelBeat(input beat_t b, input logic reluEn);
    exp_t e;
    int delta, r, s;
    e = '0;
    for (int i = 0; i < LANES; i++) begin
      e.ovf[i] = (b.q[i] == -128);
      if (b.obm[i])      delta = b.odelta[i];
      else if (e.ovf[i]) delta = 0;
      else               delta = b.q[i] * 16;
      r = (!reluEn || b.sign[i]) ? delta : 0;
      s = b.xprev[i] + r;
      e.sat[i] = (s > 32767) || (s < -32768);
      if (s > 32767)       s = 32767;
      else if (s < -32768) s = -32768;
      e.x[i*DATA_W +: DATA_W]    = DATA_W'(s);
      e.relu[i*DATA_W +: DATA_W] = DATA_W'(r);
    end
    e.last = b.last;
    return e;
  endfunction

  function automatic beat_t randBeat();
    beat_t b;
    for (int i = 0; i < LANES; i++) begin
      b.q[i]      = int'($urandom_range(0, 255)) - 128;
      b.odelta[i] = int'($urandom_range(0, 65535)) - 32768;
      b.xprev[i]  = int'($urandom_range(0, 65535)) - 32768;
    end
    b.obm  = LANES'($urandom_range(0, 15));
    b.sign = LANES'($urandom_range(0, 15));
    b.last = 1'($urandom_range(0, 1));
    return b;
  endfunction

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic applyStimulus(input beat_t b, input logic clr);
    int waited;
    exp_t e;
    for (int i = 0; i < LANES; i++) begin
      bus.in_q[i*IN_W +: IN_W]         = IN_W'(b.q[i]);
      bus.in_odelta[i*DATA_W +: DATA_W] = DATA_W'(b.odelta[i]);
      bus.in_xprev[i*DATA_W +: DATA_W]  = DATA_W'(b.xprev[i]);
    end
    bus.in_obm   = b.obm;
    bus.in_sign  = b.sign;
    bus.in_last  = b.last;
    bus.in_valid = 1'b1;
    bus.stat_clr = clr;
    waited = 0;
    @(negedge clk);
    while (!bus.in_ready && waited < 100) begin
      waited++;
      @(negedge clk);
    end
    if (waited >= 100) begin
      checkOutput("accept timeout", XW'(bus.in_ready), XW'(1));
    end else begin
      e = modelBeat(b, bus.cfg_relu_en);
      expQ.push_back(e);
      acceptCycle = cycleCount;
      if (clr) begin
        mOutliers = 0;
        mErr = 0;
        mSat = 0;
      end else begin
        mOutliers = satCnt(mOutliers + $countones(b.obm));
      end
      mErr = satCnt(mErr + $countones(e.ovf & ~b.obm));
      mSat = satCnt(mSat + $countones(e.sat));
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.stat_clr = 1'b0;
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((expQ.size() != 0 || bus.out_valid) && n < 60);
    checkOutput("drain", XW'(expQ.size()), XW'(0));
    @(posedge clk);
    #1;
  endtask

  task automatic checkStats(input string tag);
    checkOutput({tag, " stat_outliers"}, XW'(bus.stat_outliers), XW'(mOutliers));
    checkOutput({tag, " stat_err"},      XW'(bus.stat_err),      XW'(mErr));
    checkOutput({tag, " stat_sat"},      XW'(bus.stat_sat),      XW'(mSat));
  endtask

  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.out_ready = randReady ? 1'($urandom_range(0, 1)) : readyLevel;
    end
  end

  initial begin
    logic prevStall, prevLastHs;
    logic [XW-1:0] prevX;
    exp_t e;
    prevStall = 1'b0;
    prevLastHs = 1'b0;
    prevX = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prevStall = 1'b0;
        prevLastHs = 1'b0;
      end else begin
        checkOutput("tile_done", XW'(bus.tile_done), XW'(prevLastHs));
        checkOutput("in_ready", XW'(bus.in_ready), XW'(!bus.out_valid || bus.out_ready));
        if (prevStall) begin
          checkOutput("stall out_valid", XW'(bus.out_valid), XW'(1));
          checkOutput("stall out_x", bus.out_x, prevX);
        end
        prevLastHs = 1'b0;
        if (bus.out_valid && bus.out_ready) begin
          if (expQ.size() == 0) begin
            checkOutput("unexpected beat", XW'(bus.out_valid), XW'(0));
          end else begin
            e = expQ.pop_front();
            checkOutput("out_x", bus.out_x, e.x);
            checkOutput("out_relu", bus.out_relu, e.relu);
            checkOutput("out_ovf", XW'(bus.out_ovf), XW'(e.ovf));
            checkOutput("out_sat", XW'(bus.out_sat), XW'(e.sat));
            checkOutput("out_last", XW'(bus.out_last), XW'(e.last));
          end
          prevLastHs = bus.out_last;
        end
        prevStall = bus.out_valid && !bus.out_ready;
        prevX = bus.out_x;
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not reach its end");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    beat_t b;
    int n, hsCycle;
    bus.in_valid = 1'b0;
    bus.in_q = '0;
    bus.in_obm = '0;
    bus.in_odelta = '0;
    bus.in_sign = '0;
    bus.in_xprev = '0;
    bus.in_last = 1'b0;
    bus.cfg_relu_en = 1'b0;
    bus.stat_clr = 1'b0;
    rst_n = 1'b0;

    repeat (3) @(negedge clk);
    checkOutput("reset out_valid", XW'(bus.out_valid), XW'(0));
    checkOutput("reset tile_done", XW'(bus.tile_done), XW'(0));
    checkOutput("reset out_x", bus.out_x, XW'(0));
    checkOutput("reset out_relu", bus.out_relu, XW'(0));
    checkOutput("reset out_ovf/sat", XW'({bus.out_ovf, bus.out_sat, bus.out_last}), XW'(0));
    checkStats("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("in_ready after reset", XW'(bus.in_ready), XW'(1));
    @(posedge clk);
    #1;

    $display("[TB] directed decode");
    b.q = '{3, -2, -128, 5};
    b.odelta = '{0, 0, 100, 0};
    b.xprev = '{0, 0, 0, 0};
    b.obm = 4'b0100;
    b.sign = 4'b0000;
    b.last = 1'b0;
    applyStimulus(b, 1'b0);
    waitDrain();
    checkStats("decode");

    $display("[TB] relu and error");
    bus.cfg_relu_en = 1'b1;
    b.q = '{1, 1, -128, 1};
    b.odelta = '{0, 0, 0, 0};
    b.xprev = '{10, 10, 10, 10};
    b.obm = 4'b0000;
    b.sign = 4'b1101;
    applyStimulus(b, 1'b0);
    waitDrain();
    checkStats("relu");

    $display("[TB] saturation");
    b.q = '{1, 0, 0, 0};
    b.xprev = '{32760, 0, 0, 0};
    b.sign = 4'b1111;
    applyStimulus(b, 1'b0);
    b.q = '{-1, 0, 0, 0};
    b.xprev = '{-32768, 0, 0, 0};
    applyStimulus(b, 1'b0);
    waitDrain();
    checkStats("saturation");

    $display("[TB] backpressure");
    randReady = 1'b1;
    for (int k = 0; k < 8; k++) applyStimulus(randBeat(), 1'b0);
    randReady = 1'b0;
    waitDrain();
    checkStats("backpressure");

    $display("[TB] tile and latency");
    b = randBeat();
    b.last = 1'b1;
    applyStimulus(b, 1'b0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.out_valid && n < 10);
    checkOutput("latency", XW'(cycleCount - acceptCycle), XW'(2));
    hsCycle = cycleCount;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.tile_done && n < 10);
    checkOutput("tile_done delay", XW'(cycleCount - hsCycle), XW'(1));
    waitDrain();

    $display("[TB] clear with handshake");
    b.q = '{0, 0, 0, 0};
    b.odelta = '{5, 6, 7, 8};
    b.xprev = '{0, 0, 0, 0};
    b.obm = 4'b1111;
    b.sign = 4'b1111;
    b.last = 1'b0;
    applyStimulus(b, 1'b1);
    @(negedge clk);
    checkOutput("clear stat_outliers", XW'(bus.stat_outliers), XW'(0));
    checkOutput("clear stat_err", XW'(bus.stat_err), XW'(0));
    checkOutput("clear stat_sat", XW'(bus.stat_sat), XW'(0));
    waitDrain();
    checkStats("clear");

    $display("[TB] reset mid-stream");
    b = randBeat();
    b.obm = 4'b1111;
    applyStimulus(b, 1'b0);
    applyStimulus(randBeat(), 1'b0);
    rst_n = 1'b0;
    expQ.delete();
    mOutliers = 0;
    mErr = 0;
    mSat = 0;
    @(negedge clk);
    checkOutput("midreset out_valid", XW'(bus.out_valid), XW'(0));
    checkOutput("midreset out_x", bus.out_x, XW'(0));
    checkOutput("midreset out_relu", bus.out_relu, XW'(0));
    checkStats("midreset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      checkOutput("no beat after reset", XW'(bus.out_valid), XW'(0));
    end
    @(posedge clk);
    #1;
    applyStimulus(randBeat(), 1'b0);
    waitDrain();
    checkStats("recovery");

    checkOutput("scoreboard empty", XW'(expQ.size()), XW'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
